udpstreamtxarbiter400g: RTL
===========================

# udpstreamtxarbiter400g

Packet-granular round-robin arbiter that shares the single 400G UDP streaming TX port (axis_streaming_data_tx_*) of the UDP streaming application between G_NUM_STREAMS independent yellow-block AXIS sources. It grants one source per packet, holds the grant until that packet's tlast beat is accepted, and latches that source's UDP/IP metadata for the whole packet. It sits between the yellow-block AXIS streams and the UDP streaming application's TX inputs, in the axis_clk domain.

## Interface
- G_AXIS_DATA_WIDTH, 1024, AXIS data width in bits; tkeep width is G_AXIS_DATA_WIDTH/8.
- G_NUM_STREAMS, 4, number of requesting sources; legal range 2..16.
- G_IDX_WIDTH, 2, grant index width; must equal max(1, clog2(G_NUM_STREAMS)).

Ports, grouped:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - axis_clk  in  1  sole clock.
  - axis_aresetn  in  1  reset; asynchronous assert, synchronous deassert at the source.
- Source-side AXIS, stream k occupies slice k of each flattened bus:
  - s_axis_tdata  in  N*W  source data.
  - s_axis_tkeep  in  N*W/8  source byte enables.
  - s_axis_tvalid  in  N  valid, which is also the request.
  - s_axis_tlast  in  N  end of packet.
  - s_axis_tuser  in  N  passed through.
  - s_axis_tready  out  N  ready; only the granted bit can be 1.
- Source-side metadata, stream k occupies slice k:
  - s_destination_ip  in  32*N  destination IP.
  - s_destination_udp_port  in  16*N  destination UDP port.
  - s_source_udp_port  in  16*N  source UDP port.
  - s_packet_length  in  16*N  payload length in bytes.
- Flow control:
  - DataRateBackOff  in  1  while 1, no new grant is issued.
- MAC-side AXIS, to the UDP streaming TX port:
  - m_axis_tdata  out  W  data.
  - m_axis_tkeep  out  W/8  byte enables.
  - m_axis_tvalid  out  1  valid.
  - m_axis_tlast  out  1  end of packet.
  - m_axis_tuser  out  1  user bit.
  - m_axis_tready  in  1  ready from the UDP streaming application.
- MAC-side metadata:
  - m_destination_ip  out  32  latched destination IP.
  - m_destination_udp_port  out  16  latched destination port.
  - m_source_udp_port  out  16  latched source port.
  - m_packet_length  out  16  latched payload length.
- Status:
  - grant_index  out  G_IDX_WIDTH  currently or last granted stream.
  - grant_active  out  1  1 while in XFER.
  - stream_packet_count  out  32*N  per-stream count of completed packets.

## Operation
- FSM has two states, IDLE and XFER; reset state is IDLE.
- IDLE:
  - If DataRateBackOff=0 and any s_axis_tvalid bit is 1, pick the first requesting stream searching from (last_grant+1) mod N upward, wrapping.
  - Register grant_index, register that stream's four metadata fields into m_*, and go to XFER.
  - Otherwise remain in IDLE.
- XFER, with g = grant_index:
  - m_axis_tdata/tkeep/tvalid/tlast/tuser = s_axis_*[g], combinational.
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready bits are 0.
- On m_axis_tvalid & m_axis_tready & m_axis_tlast in XFER:
  - stream_packet_count[g] += 1, wrapping 2^32-1 -> 0.
  - last_grant <= g.
  - Return to IDLE.
- Outside XFER: m_axis_tvalid, tlast, tuser, tdata and tkeep are forced to 0, and all s_axis_tready bits are 0.
- m_* metadata holds its value from the grant until the next grant; it is never sampled mid-packet.
- DataRateBackOff never truncates a packet in progress; it only blocks arbitration in IDLE.
- If the granted source drops tvalid mid-packet, the grant is held indefinitely. There is no timeout.
- Requests from non-granted streams are ignored until IDLE.
- Reset values: all outputs 0; last_grant = N-1, so stream 0 wins first; all counts 0.
- Reset mid-packet: outputs go to 0 asynchronously and the packet is abandoned. The source must restart it after reset.

## Timing
- Arbitration latency: a request seen in IDLE at edge t gives grant_active=1 and the first beat presentable in the cycle after edge t, i.e. 1 cycle.
- Exactly one IDLE bubble cycle separates consecutive packets, so peak utilisation for P-beat packets is P/(P+1).
- The data path is zero-latency combinational from the granted source to m_axis. The only registers are the state, grant, metadata and counters.
- The count update and the XFER->IDLE transition occur on the same edge as the tlast handshake.
- Single-beat packets (tlast on the first beat) are legal: XFER lasts 1 cycle when m_axis_tready=1.

## Test plan
- Reset: hold axis_aresetn=0 with all sources valid -> every output 0, s_axis_tready=0000, grant_active=0.
- Single stream: stream 0 sends 8 beats with tkeep all-ones, length 1024, IP c0a80103, ports 1234/5678, m_axis_tready=1 -> grant one cycle after tvalid; 8 beats pass unchanged; m_* metadata matches; stream_packet_count[0]=1.
- Fairness: all 4 streams continuously send 8-beat packets -> grant order 0,1,2,3,0,1; one bubble between packets; after 8 packets each count is 2.
- Backpressure: m_axis_tready toggles 1010… during a stream 2 packet -> s_axis_tready[2] mirrors it; all 8 beats delivered with no loss and no duplication; other ready bits stay 0.
- Backoff: raise DataRateBackOff on beat 3 of a stream 1 packet -> the packet completes; no grant while it is high; stream 2 is granted one cycle after release.
- Reset during beat 4 of stream 3 -> outputs 0 immediately; after release, with streams 0 and 3 both requesting, stream 0 is granted.

Source files
------------

// File: rtl/udpstreamtxarbiter400g_if.sv
// udpstreamtxarbiter400g_if
// Bundles the source-side AXIS streams, their UDP/IP metadata, the single
// MAC-side AXIS stream and the latched MAC-side metadata of the 400G UDP TX
// arbiter.
//
// Signals (stream k occupies slice k of every flattened source bus):
//   s_axis_tdata/tkeep/tvalid/tlast/tuser  source AXIS beats, tvalid doubles as request
//   s_axis_tready                          per-source ready, only the granted bit can be 1
//   s_destination_ip/udp ports/length      per-source UDP/IP metadata
//   m_axis_tdata/tkeep/tvalid/tlast/tuser  arbitrated AXIS stream to the UDP TX port
//   m_axis_tready                          ready from the UDP streaming application
//   m_destination_ip/udp ports/length      metadata latched at grant time
//
// Modports:
//   master  the arbiter's view; it masters the TX port and serves the sources
//   slave   the environment's view (sources plus UDP streaming application)
interface udpstreamtxarbiter400g_if #(
   parameter int G_AXIS_DATA_WIDTH = 1024,
   parameter int G_NUM_STREAMS     = 4
);
   localparam int W = G_AXIS_DATA_WIDTH;
   localparam int N = G_NUM_STREAMS;

   logic [N*W-1:0]     s_axis_tdata;
   logic [N*W/8-1:0]   s_axis_tkeep;
   logic [N-1:0]       s_axis_tvalid;
   logic [N-1:0]       s_axis_tlast;
   logic [N-1:0]       s_axis_tuser;
   logic [N-1:0]       s_axis_tready;

   logic [32*N-1:0]    s_destination_ip;
   logic [16*N-1:0]    s_destination_udp_port;
   logic [16*N-1:0]    s_source_udp_port;
   logic [16*N-1:0]    s_packet_length;

   logic [W-1:0]       m_axis_tdata;
   logic [W/8-1:0]     m_axis_tkeep;
   logic               m_axis_tvalid;
   logic               m_axis_tlast;
   logic               m_axis_tuser;
   logic               m_axis_tready;

   logic [31:0]        m_destination_ip;
   logic [15:0]        m_destination_udp_port;
   logic [15:0]        m_source_udp_port;
   logic [15:0]        m_packet_length;

   modport master (
      input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      output s_axis_tready,
      input  s_destination_ip, s_destination_udp_port, s_source_udp_port, s_packet_length,
      output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      input  m_axis_tready,
      output m_destination_ip, m_destination_udp_port, m_source_udp_port, m_packet_length
   );

   modport slave (
      output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
      input  s_axis_tready,
      output s_destination_ip, s_destination_udp_port, s_source_udp_port, s_packet_length,
      input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
      output m_axis_tready,
      input  m_destination_ip, m_destination_udp_port, m_source_udp_port, m_packet_length
   );
endinterface

// File: rtl/udpstreamtxarbiter400g.sv
// udpstreamtxarbiter400g
// Packet-granular round-robin arbiter sharing the single 400G UDP streaming
// TX port between G_NUM_STREAMS yellow-block AXIS sources. One source is
// granted per packet; the grant is held until that packet's tlast beat is
// accepted, and the source's UDP/IP metadata is latched for the whole packet.
//
// Ports:
//   axis_clk             sole clock
//   axis_aresetn         asynchronous active-low reset
//   bus                  source/MAC AXIS streams and metadata (master modport)
//   DataRateBackOff      while 1, no new grant is issued (packets in flight finish)
//   grant_index          currently or last granted stream
//   grant_active         1 while a packet is being transferred
//   stream_packet_count  per-stream count of completed packets, 32 bits each
module udpstreamtxarbiter400g #(
   parameter int G_AXIS_DATA_WIDTH = 1024,
   parameter int G_NUM_STREAMS     = 4,
   parameter int G_IDX_WIDTH       = 2
) (
   input  logic                        axis_clk,
   input  logic                        axis_aresetn,
   udpstreamtxarbiter400g_if.master    bus,
   input  logic                        DataRateBackOff,
   output logic [G_IDX_WIDTH-1:0]      grant_index,
   output logic                        grant_active,
   output logic [32*G_NUM_STREAMS-1:0] stream_packet_count
);
   localparam int W  = G_AXIS_DATA_WIDTH;
   localparam int N  = G_NUM_STREAMS;
   localparam int KW = G_AXIS_DATA_WIDTH / 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_XFER = 1'b1;

   logic [0:0]             state;
   logic [G_IDX_WIDTH-1:0] last_grant;
   logic [G_IDX_WIDTH-1:0] next_grant;
   logic                   req_found;
   logic                   pkt_done;

   // Round-robin search: the first requester at or after last_grant+1,
   // wrapping, so the stream that just finished is considered last.
   always_comb begin
      req_found  = 1'b0;
      next_grant = last_grant;
      for (int i = 1; i <= N; i++) begin
         int cand;
         cand = (int'(last_grant) + i) % N;
         if (!req_found && bus.s_axis_tvalid[cand]) begin
            req_found  = 1'b1;
            next_grant = G_IDX_WIDTH'(cand);
         end
      end
   end

   // Zero-latency data path from the granted source; everything is held at
   // zero outside a transfer so idle cycles never look like valid beats.
   always_comb begin
      bus.m_axis_tdata  = '0;
      bus.m_axis_tkeep  = '0;
      bus.m_axis_tvalid = 1'b0;
      bus.m_axis_tlast  = 1'b0;
      bus.m_axis_tuser  = 1'b0;
      bus.s_axis_tready = '0;
      if (state == ST_XFER) begin
         bus.m_axis_tdata  = bus.s_axis_tdata[int'(grant_index)*W +: W];
         bus.m_axis_tkeep  = bus.s_axis_tkeep[int'(grant_index)*KW +: KW];
         bus.m_axis_tvalid = bus.s_axis_tvalid[grant_index];
         bus.m_axis_tlast  = bus.s_axis_tlast[grant_index];
         bus.m_axis_tuser  = bus.s_axis_tuser[grant_index];
         bus.s_axis_tready[grant_index] = bus.m_axis_tready;
      end
   end

   assign pkt_done     = (state == ST_XFER) && bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast;
   assign grant_active = (state == ST_XFER);

   // State, grant, metadata latch and packet counters. last_grant resets to
   // N-1 so that stream 0 wins the first arbitration after reset.
   always_ff @(posedge axis_clk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state                      <= ST_IDLE;
         grant_index                <= '0;
         last_grant                 <= G_IDX_WIDTH'(N - 1);
         bus.m_destination_ip       <= '0;
         bus.m_destination_udp_port <= '0;
         bus.m_source_udp_port      <= '0;
         bus.m_packet_length        <= '0;
         stream_packet_count        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!DataRateBackOff && req_found) begin
                  grant_index                <= next_grant;
                  bus.m_destination_ip       <= bus.s_destination_ip[int'(next_grant)*32 +: 32];
                  bus.m_destination_udp_port <= bus.s_destination_udp_port[int'(next_grant)*16 +: 16];
                  bus.m_source_udp_port      <= bus.s_source_udp_port[int'(next_grant)*16 +: 16];
                  bus.m_packet_length        <= bus.s_packet_length[int'(next_grant)*16 +: 16];
                  state                      <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (pkt_done) begin
                  stream_packet_count[int'(grant_index)*32 +: 32] <=
                     stream_packet_count[int'(grant_index)*32 +: 32] + 32'd1;
                  last_grant <= grant_index;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
